// File: rtl/z_packer_pkg.sv
// Shared types and helpers for the Z word packer (collector + output stage).
// No logic of its own; sizes the bit counter and names the output FSM states.
// Optional feature macro used by the top: Z_PACKER_PARITY_EN.
package z_packer_pkg;

    localparam int Z_PACKER_WIDTH_DEF = 8;

    // Output holding register occupancy.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } outState_t;

    // Bits needed to count 0..width-1, never less than one.
    function automatic int cntWidth(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/z_bit_shifter.sv
// Collects qualified serial Z bits MSB-first and flags each completed WIDTH-bit word.
// Latency: Done/DoneWord are combinational on the edge that samples the final bit.
// Backpressure: none; the collector always accepts a qualified bit and wraps after a word.
module z_bit_shifter
    import z_packer_pkg::*;
#(
    parameter int WIDTH = Z_PACKER_WIDTH_DEF
)
(
    input  logic             ClkM,
    input  logic             RstM,
    input  logic             Z,
    input  logic             ZEn,
    output logic             Done,
    output logic [WIDTH-1:0] DoneWord
);

    localparam int              CW      = cntWidth(WIDTH);
    localparam int              SW      = WIDTH - 1;
    localparam logic [CW-1:0]   CntLast = CW'(WIDTH - 1);

    // Only the WIDTH-1 most recent bits are kept: the oldest bit of a full
    // WIDTH-bit window would be shifted out at the very edge it completes,
    // so it is never observed and storing it buys nothing.
    logic [SW-1:0] Shift;
    logic [CW-1:0] Cnt;

    assign Done     = ZEn && (Cnt == CntLast);
    assign DoneWord = {Shift, Z};

    // Shift in the qualified bit and advance the bit counter, wrapping on completion.
    always_ff @(posedge ClkM or posedge RstM) begin
        if (RstM) begin
            Shift <= '0;
            Cnt   <= '0;
        end else if (ZEn) begin
            Shift <= SW'({Shift, Z});
            Cnt   <= Done ? '0 : Cnt + 1'b1;
        end
    end

endmodule

// File: rtl/z_word_packer.sv
// Packs serial Z bits MSB-first into WIDTH-bit words behind a single valid/ready holding register.
// Latency: Word/WordValid load on the same edge that samples the last bit of the word.
// Backpressure: a word completing while the register is full and not being taken is dropped and sets sticky Overrun.
// Optional WordParity output (even parity of Word) is built when Z_PACKER_PARITY_EN is defined.
module z_word_packer
    import z_packer_pkg::*;
#(
    parameter int WIDTH = Z_PACKER_WIDTH_DEF
)
(
    input  logic             ClkM,
    input  logic             RstM,
    input  logic             Z,
    input  logic             ZEn,
    output logic [WIDTH-1:0] Word,
    output logic             WordValid,
    input  logic             WordReady,
    output logic             Overrun,
    input  logic             OverrunClr
`ifdef Z_PACKER_PARITY_EN
    ,
    output logic             WordParity
`endif
);

    outState_t        state;
    logic             done;
    logic [WIDTH-1:0] doneWord;
    logic             loadWord;
    logic             dropWord;

    z_bit_shifter #(
        .WIDTH    (WIDTH)
    ) uShifter (
        .ClkM     (ClkM),
        .RstM     (RstM),
        .Z        (Z),
        .ZEn      (ZEn),
        .Done     (done),
        .DoneWord (doneWord)
    );

    // A completed word is taken if the register is empty or being drained this edge.
    assign loadWord = done && ((state == EMPTY) || WordReady);
    assign dropWord = done && (state == FULL) && !WordReady;

    // The FSM state bit is the valid flag itself, so WordValid is a flop output.
    assign WordValid = (state == FULL);

    // Holding register and occupancy FSM; Word only changes on a load.
    always_ff @(posedge ClkM or posedge RstM) begin
        if (RstM) begin
            state <= EMPTY;
            Word  <= '0;
        end else begin
            if (loadWord) begin
                Word <= doneWord;
            end
            case (state)
                EMPTY:   if (done) state <= FULL;
                FULL:    if (WordReady && !done) state <= EMPTY;
                default: state <= EMPTY;
            endcase
        end
    end

    // Sticky overrun; a new drop on the same edge as a clear keeps it set.
    always_ff @(posedge ClkM or posedge RstM) begin
        if (RstM) begin
            Overrun <= 1'b0;
        end else if (dropWord) begin
            Overrun <= 1'b1;
        end else if (OverrunClr) begin
            Overrun <= 1'b0;
        end
    end

`ifdef Z_PACKER_PARITY_EN
    // Parity travels with Word: loaded on the same edge, held otherwise.
    always_ff @(posedge ClkM or posedge RstM) begin
        if (RstM) begin
            WordParity <= 1'b0;
        end else if (loadWord) begin
            WordParity <= ^doneWord;
        end
    end
`endif

endmodule

// File: tb/tb_z_word_packer.sv
// Directed, table-driven bench for z_word_packer (WIDTH=8).
// Inputs change on the falling edge; outputs are compared 1 time unit after the rising edge.
// Optional parity checks are compiled in when Z_PACKER_PARITY_EN is defined.
module tb_z_word_packer;

    logic       ClkM = 1'b0;
    logic       RstM;
    logic       Z;
    logic       ZEn;
    logic       WordReady;
    logic       OverrunClr;
    logic [7:0] Word;
    logic       WordValid;
    logic       Overrun;
`ifdef Z_PACKER_PARITY_EN
    logic       WordParity;
`endif

    always #5 ClkM = ~ClkM;

    z_word_packer #(
        .WIDTH      (8)
    ) dut (
        .ClkM       (ClkM),
        .RstM       (RstM),
        .Z          (Z),
        .ZEn        (ZEn),
        .Word       (Word),
        .WordValid  (WordValid),
        .WordReady  (WordReady),
        .Overrun    (Overrun),
        .OverrunClr (OverrunClr)
`ifdef Z_PACKER_PARITY_EN
        ,
        .WordParity (WordParity)
`endif
    );

    typedef struct {
        string      tag;
        logic       rst;
        logic       z;
        logic       zEn;
        logic       rdy;
        logic       clr;
        logic [7:0] expWord;
        logic       expValid;
        logic       expOv;
    } vec_t;

    vec_t vecs[$];
    int   applied     = 0;
    int   miscompares = 0;

    task automatic addVec(input string tag, input logic rst, input logic z, input logic zEn,
                          input logic rdy, input logic clr, input logic [7:0] w,
                          input logic v, input logic o);
        vec_t e;
        e.tag = tag; e.rst = rst; e.z = z; e.zEn = zEn; e.rdy = rdy; e.clr = clr;
        e.expWord = w; e.expValid = v; e.expOv = o;
        vecs.push_back(e);
    endtask

    // Eight qualified bits MSB-first: the first seven share one expectation, the last has its own.
    task automatic addByte(input string tag, input logic [7:0] bits,
                           input logic rdyMid, input logic rdyLast, input logic clrLast,
                           input logic [7:0] midW, input logic midV, input logic midO,
                           input logic [7:0] endW, input logic endV, input logic endO);
        for (int i = 7; i >= 1; i--) begin
            addVec(tag, 1'b0, bits[i], 1'b1, rdyMid, 1'b0, midW, midV, midO);
        end
        addVec(tag, 1'b0, bits[0], 1'b1, rdyLast, clrLast, endW, endV, endO);
    endtask

    task automatic checkOut(input string tag, input logic [7:0] w, input logic v, input logic o);
        applied++;
        if (Word !== w || WordValid !== v || Overrun !== o) begin
            miscompares++;
            $display("FAIL %s: got Word=%h WordValid=%b Overrun=%b, want Word=%h WordValid=%b Overrun=%b",
                     tag, Word, WordValid, Overrun, w, v, o);
        end
`ifdef Z_PACKER_PARITY_EN
        applied++;
        if (WordParity !== ^w) begin
            miscompares++;
            $display("FAIL %s parity: got %b, want %b", tag, WordParity, ^w);
        end
`endif
    endtask

    task automatic driveBit(input logic z, input logic zEn, input logic rdy, input logic clr);
        @(negedge ClkM);
        Z = z; ZEn = zEn; WordReady = rdy; OverrunClr = clr;
        @(posedge ClkM);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] bits, input logic rdy);
        for (int i = 7; i >= 0; i--) driveBit(bits[i], 1'b1, rdy, 1'b0);
    endtask

    initial begin
        logic [7:0] gapBits;
        RstM = 1'b1; Z = 1'b0; ZEn = 1'b0; WordReady = 1'b0; OverrunClr = 1'b0;

        // Reset, partial word, reset again, then a full word.
        addVec("reset", 1, 0, 0, 1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 5; i++) addVec("partial", 0, 1, 1, 1, 0, 8'h00, 0, 0);
        addVec("midrst", 1, 0, 1, 1, 0, 8'h00, 0, 0);
        addByte("rstword", 8'hB2, 1, 1, 0, 8'h00, 0, 0, 8'hB2, 1, 0);
        addVec("rstdrain", 0, 0, 0, 1, 0, 8'hB2, 0, 0);

        // Gapped qualifier; Z is driven high on the gaps so a wrongly sampled gap corrupts the word.
        gapBits = 8'hB2;
        for (int i = 7; i >= 0; i--) begin
            addVec("gapbit", 0, gapBits[i], 1, 1, 0, 8'hB2, (i == 0), 0);
            if (i != 0) addVec("gapidle", 0, 1, 0, 1, 0, 8'hB2, 0, 0);
        end
        addVec("gapdrain", 0, 0, 0, 1, 0, 8'hB2, 0, 0);

        // Back-to-back words with the consumer always ready.
        addByte("b2b0", 8'hFF, 1, 1, 0, 8'hB2, 0, 0, 8'hFF, 1, 0);
        addByte("b2b1", 8'h01, 1, 1, 0, 8'hFF, 0, 0, 8'h01, 1, 0);
        addVec("b2bdrain", 0, 0, 0, 1, 0, 8'h01, 0, 0);

        // Backpressure: second word dropped, overrun set, first word kept.
        addByte("bp0", 8'hA5, 0, 0, 0, 8'h01, 0, 0, 8'hA5, 1, 0);
        addByte("bp1", 8'h3C, 0, 0, 0, 8'hA5, 1, 0, 8'hA5, 1, 1);
        addVec("bphs", 0, 0, 0, 1, 0, 8'hA5, 0, 1);
        addVec("bpsticky", 0, 0, 0, 0, 0, 8'hA5, 0, 1);

        // Clear on the same edge as a new overrun: set wins, then a lone clear works.
        addByte("cs0", 8'h0F, 0, 0, 0, 8'hA5, 0, 1, 8'h0F, 1, 1);
        addByte("cs1", 8'hF0, 0, 0, 1, 8'h0F, 1, 1, 8'h0F, 1, 1);
        addVec("csclr", 0, 0, 0, 0, 1, 8'h0F, 1, 0);
        addVec("csdrain", 0, 0, 0, 1, 0, 8'h0F, 0, 0);

        // Handshake and completion on the same edge: reload, stay full, no overrun.
        addByte("hs0", 8'h81, 0, 0, 0, 8'h0F, 0, 0, 8'h81, 1, 0);
        addByte("hs1", 8'h7E, 0, 1, 0, 8'h81, 1, 0, 8'h7E, 1, 0);
        addVec("hsdrain", 0, 0, 0, 1, 0, 8'h7E, 0, 0);

        foreach (vecs[k]) begin
            @(negedge ClkM);
            RstM = vecs[k].rst; Z = vecs[k].z; ZEn = vecs[k].zEn;
            WordReady = vecs[k].rdy; OverrunClr = vecs[k].clr;
            @(posedge ClkM);
            #1;
            checkOut(vecs[k].tag, vecs[k].expWord, vecs[k].expValid, vecs[k].expOv);
        end

        // Asynchronous reset between edges while a word is held.
        sendByte(8'h55, 1'b0);
        checkOut("arstpre", 8'h55, 1'b1, 1'b0);
        #2 RstM = 1'b1;
        #1 checkOut("arst", 8'h00, 1'b0, 1'b0);
        @(negedge ClkM);
        RstM = 1'b0;
        driveBit(1'b0, 1'b0, 1'b1, 1'b0);
        checkOut("arstidle", 8'h00, 1'b0, 1'b0);

`ifdef Z_PACKER_PARITY_EN
        // Parity aligned with its word.
        sendByte(8'hB2, 1'b1);
        applied++;
        if (Word !== 8'hB2 || WordParity !== 1'b0) begin
            miscompares++;
            $display("FAIL par0: got Word=%h WordParity=%b, want Word=b2 WordParity=0", Word, WordParity);
        end
        sendByte(8'hB3, 1'b1);
        applied++;
        if (Word !== 8'hB3 || WordParity !== 1'b1) begin
            miscompares++;
            $display("FAIL par1: got Word=%h WordParity=%b, want Word=b3 WordParity=1", Word, WordParity);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
